// File: rtl/fpu_result_stage_pkg.sv
// fpu_defs: result width, flag bit positions and the packed IEEE flag vector shared by the result stage.
package fpu_defs;

    localparam int C_OP      = 32;
    localparam int C_FLAG_NV = 4;
    localparam int C_FLAG_DZ = 3;
    localparam int C_FLAG_OF = 2;
    localparam int C_FLAG_UF = 1;
    localparam int C_FLAG_NX = 0;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // An invalid operation never also reports inexact.
    function automatic fflags_t pack_flags(input logic iv, input logic inf, input logic ovf,
                                           input logic unf, input logic ix);
        return '{nv: iv, dz: inf, of: ovf, uf: unf, nx: ix & ~iv};
    endfunction

endpackage

// File: rtl/fpu_result_stage_skid.sv
// fpu_skid_buf: two-entry (main + skid) register buffer; ready depends only on the skid register.
module fpu_skid_buf #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         retire;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign retire   = out_valid & out_ready;

    // Main holds the oldest entry; skid only fills when main is held, and drains into main on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (retire) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_result_stage.sv
// fpu_result_stage: buffers converter results with packed IEEE flags; optional sticky fflags via FPU_STICKY_FLAGS_EN.
module fpu_result_stage
    import fpu_defs::*;
(
    input  logic            Clk_CI,
    input  logic            Rst_RBI,
    input  logic            In_Valid_SI,
    output logic            In_Ready_SO,
    input  logic [C_OP-1:0] Result_DI,
    input  logic            OF_SI,
    input  logic            UF_SI,
    input  logic            Zero_SI,
    input  logic            IX_SI,
    input  logic            IV_SI,
    input  logic            Inf_SI,
    output logic            Out_Valid_SO,
    input  logic            Out_Ready_SI,
    output logic [C_OP-1:0] Result_DO,
    output logic [4:0]      Flags_DO,
    output logic            Zero_SO,
    output logic [4:0]      Sticky_DO,
    input  logic            Sticky_Clr_SI,
    input  logic            Sticky_We_SI,
    input  logic [4:0]      Sticky_DI
);

    localparam int W = C_OP + 5 + 1;

    fflags_t      flags_in;
    logic [W-1:0] buf_out;

    assign flags_in = pack_flags(IV_SI, Inf_SI, OF_SI, UF_SI, IX_SI);

    fpu_skid_buf #(.W(W)) u_buf (
        .clk       (Clk_CI),
        .rst_n     (Rst_RBI),
        .in_valid  (In_Valid_SI),
        .in_ready  (In_Ready_SO),
        .in_data   ({Result_DI, flags_in, Zero_SI}),
        .out_valid (Out_Valid_SO),
        .out_ready (Out_Ready_SI),
        .out_data  (buf_out)
    );

    assign {Result_DO, Flags_DO, Zero_SO} = buf_out;

`ifdef FPU_STICKY_FLAGS_EN
    logic [4:0] retire_flags;

    assign retire_flags = (Out_Valid_SO & Out_Ready_SI) ? Flags_DO : 5'b0;

    // CSR clear beats CSR write, which beats plain accumulation of retiring flags.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) Sticky_DO <= '0;
        else Sticky_DO <= Sticky_Clr_SI ? 5'b0 :
                          Sticky_We_SI  ? (Sticky_DI | retire_flags) :
                                          (Sticky_DO | retire_flags);
    end
`else
    logic unused_sticky;

    assign unused_sticky = ^{Sticky_Clr_SI, Sticky_We_SI, Sticky_DI};
    assign Sticky_DO     = '0;
`endif

endmodule
